// File: rtl/wm_controller_if.sv
// Sensor/flag inputs and actuator/state outputs of the washing-machine controller.
interface wm_controller_if;
  logic       coin_In;
  logic       heat_Enable;
  logic       lid_Open;
  logic       cancel;
  logic       sig_Full;
  logic       sig_Temperature;
  logic       sig_Wash_Completed;
  logic       sig_Rinse_Completed;
  logic       sig_Spin_Completed;
  logic [2:0] state;
  logic       door_Lock;
  logic       water_Valve;
  logic       heater_On;
  logic       motor_On;
  logic       drain_Valve;
  logic       done;
  logic       error;

  modport master (
    output coin_In, heat_Enable, lid_Open, cancel,
           sig_Full, sig_Temperature, sig_Wash_Completed,
           sig_Rinse_Completed, sig_Spin_Completed,
    input  state, door_Lock, water_Valve, heater_On, motor_On,
           drain_Valve, done, error
  );

  modport slave (
    input  coin_In, heat_Enable, lid_Open, cancel,
           sig_Full, sig_Temperature, sig_Wash_Completed,
           sig_Rinse_Completed, sig_Spin_Completed,
    output state, door_Lock, water_Valve, heater_On, motor_On,
           drain_Valve, done, error
  );
endinterface

// File: rtl/wm_controller.sv
// Washing-machine main FSM: stage sequencing on timer flags, cancel, optional
// heat stage, per-stage watchdog and Moore actuator decode.
module wm_controller #(
  parameter int TIMEOUT     = 20,
  parameter int TIMER_WIDTH = 5
) (
  input  logic          clock,
  input  logic          reset,
  wm_controller_if.slave bus
);
  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_HEAT  = 3'd3;
  localparam logic [2:0] S_WASH  = 3'd4;
  localparam logic [2:0] S_RINSE = 3'd5;
  localparam logic [2:0] S_SPIN  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [TIMER_WIDTH-1:0] WD_LIMIT = TIMER_WIDTH'(TIMEOUT);

  logic [2:0]             state_q, state_d;
  logic                   heat_sel_q, heat_sel_d;
  logic [TIMER_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
  logic                   error_q, error_d;
  logic                   stage_flag;
  logic [2:0]             adv_state;

  // Only the flag owned by the current stage matters; stale sticky flags are ignored.
  always_comb begin
    stage_flag = 1'b0;
    adv_state  = state_q;
    case (state_q)
      S_FILL:  begin stage_flag = bus.sig_Full;            adv_state = heat_sel_q ? S_HEAT : S_WASH; end
      S_HEAT:  begin stage_flag = bus.sig_Temperature;     adv_state = S_WASH;  end
      S_WASH:  begin stage_flag = bus.sig_Wash_Completed;  adv_state = S_RINSE; end
      S_RINSE: begin stage_flag = bus.sig_Rinse_Completed; adv_state = S_SPIN;  end
      S_SPIN:  begin stage_flag = bus.sig_Spin_Completed;  adv_state = S_DONE;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    heat_sel_d = heat_sel_q;
    error_d    = error_q;
    wd_cnt_d   = '0;
    case (state_q)
      S_START: begin
        if (bus.coin_In && !bus.lid_Open) begin
          state_d    = S_READY;
          heat_sel_d = bus.heat_Enable;
          error_d    = 1'b0;
        end
      end
      S_READY: state_d = bus.cancel ? S_START : S_FILL;
      S_DONE:  if (bus.lid_Open) state_d = S_START;
      default: begin
        // Priority: cancel, then stage completion, then watchdog expiry.
        if (bus.cancel) begin
          state_d = S_START;
        end else if (stage_flag) begin
          state_d = adv_state;
        end else if (wd_cnt_q == WD_LIMIT) begin
          state_d = S_START;
          error_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_START;
      heat_sel_q <= 1'b0;
      wd_cnt_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      heat_sel_q <= heat_sel_d;
      wd_cnt_q   <= wd_cnt_d;
      error_q    <= error_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.door_Lock   = (state_q != S_START) && (state_q != S_DONE);
  assign bus.water_Valve = (state_q == S_FILL) || (state_q == S_RINSE);
  assign bus.heater_On   = (state_q == S_HEAT);
  assign bus.motor_On    = (state_q == S_WASH) || (state_q == S_RINSE) || (state_q == S_SPIN);
  assign bus.drain_Valve = (state_q == S_SPIN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.error       = error_q;
endmodule

// File: tb/tb_wm_controller.sv
// Directed + randomized bench for wm_controller against a stage-table reference model.
module tb_wm_controller;
  localparam int TIMEOUT = 20;

  logic       clock;
  logic       reset;
  logic       coin, heat_en, lid, cancel;
  logic [4:0] flg;  // {spin, rinse, wash, temperature, full}

  wm_controller_if bus ();

  assign bus.coin_In             = coin;
  assign bus.heat_Enable         = heat_en;
  assign bus.lid_Open            = lid;
  assign bus.cancel              = cancel;
  assign bus.sig_Full            = flg[0];
  assign bus.sig_Temperature     = flg[1];
  assign bus.sig_Wash_Completed  = flg[2];
  assign bus.sig_Rinse_Completed = flg[3];
  assign bus.sig_Spin_Completed  = flg[4];

  wm_controller #(.TIMEOUT(TIMEOUT), .TIMER_WIDTH(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {door_Lock, water_Valve, heater_On, motor_On, drain_Valve, done} per state.
  logic [5:0] exp_out [8] = '{6'b000000, 6'b100000, 6'b110000, 6'b101000,
                              6'b100100, 6'b110100, 6'b100110, 6'b000001};

  int m_state, m_age;
  bit m_heat, m_err;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [7:0] dut_outs();
    return {1'b0, bus.door_Lock, bus.water_Valve, bus.heater_On,
            bus.motor_On, bus.drain_Valve, bus.done, bus.error};
  endfunction

  task automatic check_model();
    chk("state", {5'd0, bus.state}, 8'(m_state));
    chk("outputs", dut_outs(), {1'b0, exp_out[m_state], m_err});
  endtask

  task automatic model_reset();
    m_state = 0; m_age = 0; m_heat = 0; m_err = 0;
  endtask

  // One clock: predict next state from current inputs, then compare after the edge.
  task automatic cycle();
    int ns, na;
    bit nh, ne;
    ns = m_state; na = m_age + 1; nh = m_heat; ne = m_err;
    case (m_state)
      0: begin na = 0; if (coin && !lid) begin ns = 1; nh = heat_en; ne = 0; end end
      1: begin na = 0; ns = cancel ? 0 : 2; end
      7: begin na = 0; if (lid) ns = 0; end
      default: begin
        if (cancel) ns = 0;
        else if (flg[m_state-2]) ns = (m_state == 2 && !m_heat) ? 4 : m_state + 1;
        else if (m_age >= TIMEOUT) begin ns = 0; ne = 1; end
      end
    endcase
    if (ns != m_state) na = 0;
    @(posedge clock);
    #1;
    cyc++;
    m_state = ns; m_age = na; m_heat = nh; m_err = ne;
    check_model();
  endtask

  task automatic start(input bit heat);
    coin = 1; heat_en = heat;
    cycle();
    coin = 0; heat_en = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_current();
    int idx;
    idx = m_state - 2;
    flg[idx] = 1'b1;
    cycle();
    flg[idx] = 1'b0;
  endtask

  task automatic goto_state(input int target);
    int guard = 0;
    while (m_state != target && guard < 50) begin
      if (m_state >= 2 && m_state <= 6) pulse_current();
      else cycle();
      guard++;
    end
    chk("goto", 8'(m_state), 8'(target));
  endtask

  // Full program: each stage flag raised dly cycles after the stage is entered.
  task automatic run_prog(input bit heat, input int dly, input bit hold);
    int cnt = 0, prev, guard = 0, idx;
    start(heat);
    prev = m_state;
    while (m_state >= 1 && m_state <= 6 && guard < 400) begin
      if (m_state >= 2) lid = 1'($urandom_range(0, 1));
      if (m_state >= 2 && cnt == dly) begin
        idx = m_state - 2;
        flg[idx] = 1'b1;
        cycle();
        if (!hold) flg[idx] = 1'b0;
      end else begin
        cycle();
      end
      guard++;
      if (m_state != prev) begin cnt = 0; prev = m_state; end
      else cnt++;
    end
    lid = 0;
    if (guard >= 400) begin
      n_cmp++; n_err++;
      $error("FAIL run_bound cyc=%0d observed=%0d expected=<400", cyc, guard);
    end
    if (m_state == 7) begin
      cancel = 1; coin = 1;
      repeat (2) cycle();
      cancel = 0; coin = 0;
      chk("done_hold", {5'd0, bus.state}, 8'd7);
      lid = 1;
      cycle();
      lid = 0;
      chk("done_release", {7'd0, bus.done}, 8'd0);
    end
    flg = '0;
    $display("prog heat=%0d dly=%0d hold=%0d end_state=%0d err=%0d cyc=%0d",
             heat, dly, hold, m_state, m_err, cyc);
  endtask

  initial begin
    coin = 0; heat_en = 0; lid = 0; cancel = 0; flg = '0;
    reset = 0;
    model_reset();
    #1;
    chk("reset_state", {5'd0, bus.state}, 8'd0);
    chk("reset_outs", dut_outs(), 8'd0);
    #1 reset = 1;
    cycle();

    // Normal heat cycle, then no-heat cycle.
    run_prog(1'b1, 3, 1'b0);
    run_prog(1'b0, 3, 1'b0);

    // Stale sticky flags held high must not skip WASH.
    run_prog(1'b1, 2, 1'b1);

    // Cancel in WASH.
    start(1'b0);
    goto_state(4);
    cycle();
    cancel = 1;
    cycle();
    cancel = 0;
    chk("cancel_state", {5'd0, bus.state}, 8'd0);
    chk("cancel_outs", dut_outs(), 8'd0);
    $display("cancel in WASH state=%0d cyc=%0d", bus.state, cyc);

    // Watchdog expiry in FILL: abort on the 21st edge after entry.
    start(1'b0);
    cycle();
    repeat (TIMEOUT) cycle();
    chk("wd_pre", {5'd0, bus.state}, 8'd2);
    cycle();
    chk("wd_abort_state", {5'd0, bus.state}, 8'd0);
    chk("wd_abort_err", {7'd0, bus.error}, 8'd1);
    repeat (2) cycle();
    chk("wd_err_sticky", {7'd0, bus.error}, 8'd1);
    start(1'b1);
    chk("wd_err_clear", {7'd0, bus.error}, 8'd0);
    $display("watchdog abort + restart cyc=%0d", cyc);

    // Completion on exactly the timeout cycle wins.
    cycle();
    repeat (TIMEOUT) cycle();
    pulse_current();
    chk("wd_race_state", {5'd0, bus.state}, 8'd3);
    chk("wd_race_err", {7'd0, bus.error}, 8'd0);
    cancel = 1;
    cycle();
    cancel = 0;
    $display("watchdog race state=%0d cyc=%0d", bus.state, cyc);

    // Lid interlock at START.
    lid = 1; coin = 1;
    repeat (3) cycle();
    lid = 0; coin = 0;
    chk("lid_interlock", {5'd0, bus.state}, 8'd0);

    // Randomized programs, including delays that may hit the watchdog.
    for (int i = 0; i < 6; i++) begin
      run_prog(1'($urandom_range(0, 1)), int'($urandom_range(0, 22)), 1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 2))) cycle();
    end

    // Asynchronous reset mid-SPIN, between clock edges.
    start(1'b1);
    goto_state(6);
    #2 reset = 0;
    #1;
    model_reset();
    chk("async_state", {5'd0, bus.state}, 8'd0);
    chk("async_outs", dut_outs(), 8'd0);
    #3 reset = 1;
    cycle();
    $display("async reset in SPIN state=%0d cyc=%0d", bus.state, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
